fetch_buffer: RTL and testbench

Instruction prefetch queue between the synchronous instruction memory and the IF/ID pipeline register. It owns the fetch PC and issues sequential fetch requests. Returned instructions are held, tagged with their PC, in a DEPTH-entry FIFO. The decode side pops them with a valid/ready handshake. A branch/jump redirect from EX flushes the queue, kills any in-flight fetch and restarts fetching at the target.

---
 rtl/fetch_buffer.sv | 100 ++++++++++
 tb/tb_fetch_buffer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - instruction prefetch queue between imem and the IF/ID register
module fetch_buffer #(
    parameter int PC_W  = 9,
    parameter int INS_W = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       redirect,
    input  logic [PC_W-1:0]            redirect_pc,
    output logic                       imem_req,
    output logic [PC_W-1:0]            imem_addr,
    input  logic [INS_W-1:0]           imem_rdata,
    output logic                       out_valid,
    output logic [PC_W-1:0]            out_pc,
    output logic [INS_W-1:0]           out_instr,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PC_W-1:0]  fetch_pc;
    logic [PC_W-1:0]  pend_pc;
    logic             pend_v;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt_q;
    logic [PC_W-1:0]  mem_pc  [DEPTH];
    logic [INS_W-1:0] mem_ins [DEPTH];

    logic [CNT_W:0]   used;
    logic             issue;
    logic             push;
    logic             pop;

    // An in-flight fetch already owns a FIFO slot, so it counts against the credit.
    assign used      = {1'b0, cnt_q} + {{CNT_W{1'b0}}, pend_v};
    assign issue     = !reset && !redirect && (used < (CNT_W+1)'(DEPTH));
    assign push      = pend_v && !redirect;
    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid && out_ready && !redirect;

    assign imem_req  = issue;
    assign imem_addr = fetch_pc;
    assign count     = cnt_q;
    assign out_pc    = out_valid ? mem_pc[rd_ptr]  : '0;
    assign out_instr = out_valid ? mem_ins[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= '0;
            pend_pc  <= '0;
            pend_v   <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt_q    <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            pend_v   <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt_q    <= '0;
        end else begin
            if (issue) begin
                pend_v   <= 1'b1;
                pend_pc  <= fetch_pc;
                fetch_pc <= fetch_pc + PC_W'(4);
            end else begin
                pend_v   <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_pc[wr_ptr]  <= pend_pc;
            mem_ins[wr_ptr] <= imem_rdata;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        push |-> (cnt_q < CNT_W'(DEPTH)));
    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        cnt_q <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - randomized self-checking bench for fetch_buffer
module tb_fetch_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        redirect;
    logic [8:0]  redirect_pc;
    logic        imem_req;
    logic [8:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [8:0]  out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
    logic [2:0]  count;

    int n_pass  = 0;
    int n_total = 0;

    logic [8:0] q[$];
    bit         pend;
    logic [8:0] pend_pc;
    logic [8:0] fpc;
    logic [8:0] next_pc;
    bit         have_next;
    bit         init;

    fetch_buffer #(.PC_W(9), .INS_W(32), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .out_ready   (out_ready),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [8:0] pc);
        return 32'h1000_0000 | {23'b0, pc};
    endfunction

    always @(posedge clk) imem_rdata <= instr_of(imem_addr);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    // One clock cycle: drive inputs, compare outputs against the model, then advance the model.
    task automatic step(input logic rst, input logic rd, input logic [8:0] rpc, input logic rdy);
        bit exp_req;
        @(posedge clk);
        #1;
        reset = rst; redirect = rd; redirect_pc = rpc; out_ready = rdy;
        @(negedge clk);
        if (init) begin
            exp_req = !rst && !rd && (q.size() + int'(pend) < DEPTH);
            check("imem_req", imem_req, exp_req);
            check("imem_addr", imem_addr, fpc);
            check("out_valid", out_valid, q.size() != 0);
            check("out_pc", out_pc, (q.size() != 0) ? q[0] : 9'd0);
            check("out_instr", out_instr, (q.size() != 0) ? instr_of(q[0]) : 32'd0);
            check("count", count, q.size());
            check("count_max", count <= 3'(DEPTH), 1);
        end
        if (rst) begin
            q.delete(); pend = 0; fpc = '0;
            next_pc = '0; have_next = 1; init = 1;
        end else if (rd) begin
            q.delete(); pend = 0; fpc = rpc;
            next_pc = rpc; have_next = 1;
        end else begin
            exp_req = (q.size() + int'(pend) < DEPTH);
            if (q.size() != 0 && rdy) begin
                if (have_next) check("stream_pc", out_pc, next_pc);
                next_pc = next_pc + 9'd4;
                void'(q.pop_front());
            end
            if (pend) q.push_back(pend_pc);
            if (exp_req) begin
                pend = 1; pend_pc = fpc; fpc = fpc + 9'd4;
            end else begin
                pend = 0;
            end
        end
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0);
        step(1, 1, 9'h80, 1);
    endtask

    initial begin
        reset = 1; redirect = 0; redirect_pc = 0; out_ready = 0;
        init = 0; pend = 0; fpc = 0; have_next = 0; next_pc = 0;

        // streaming at one instruction per cycle
        do_reset();
        for (int c = 0; c < 8; c++) begin
            step(0, 0, 0, 1);
            if (c == 1) check("t1_not_yet", out_valid, 0);
            if (c >= 2) begin
                check("t1_valid", out_valid, 1);
                check("t1_pc", out_pc, 9'(4 * (c - 2)));
                check("t1_instr", out_instr, 32'h1000_0000 | 32'(4 * (c - 2)));
            end
        end

        // stall until full, then drain without bubbles
        do_reset();
        for (int c = 0; c < 7; c++) step(0, 0, 0, 0);
        check("t2_full_count", count, 4);
        check("t2_full_req", imem_req, 0);
        check("t2_full_addr", imem_addr, 16);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 1);
            check("t2_drain_valid", out_valid, 1);
            check("t2_drain_pc", out_pc, 9'(4 * i));
        end

        // redirect with a pending fetch and three entries queued
        do_reset();
        for (int c = 0; c < 4; c++) step(0, 0, 0, 0);
        step(0, 1, 9'h40, 0);
        check("t3_count_before", count, 3);
        step(0, 0, 0, 1);
        check("t3_count_after", count, 0);
        check("t3_valid_after", out_valid, 0);
        check("t3_req", imem_req, 1);
        check("t3_addr", imem_addr, 9'h40);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("t3_target_valid", out_valid, 1);
        check("t3_target_pc", out_pc, 9'h40);
        for (int c = 0; c < 4; c++) step(0, 0, 0, 1);

        // redirect coincident with a ready head; reset beats redirect
        do_reset();
        for (int c = 0; c < 3; c++) step(0, 0, 0, 1);
        step(0, 1, 9'h20, 1);
        check("t4_head_valid", out_valid, 1);
        step(0, 0, 0, 1);
        check("t4_empty_count", count, 0);
        check("t4_empty_valid", out_valid, 0);
        step(1, 1, 9'h80, 0);
        step(0, 0, 0, 0);
        check("t4_reset_addr", imem_addr, 0);
        check("t4_reset_req", imem_req, 1);

        // fetch_pc wraps modulo 2^9
        step(0, 1, 9'h1FC, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("t5_pc_1fc", out_pc, 9'h1FC);
        step(0, 0, 0, 1);
        check("t5_pc_000", out_pc, 9'h000);
        step(0, 0, 0, 1);
        check("t5_pc_004", out_pc, 9'h004);

        // random ready and redirects against the model
        for (int c = 0; c < 10000; c++) begin
            logic rd;
            logic rdy;
            logic [8:0] rpc;
            rd  = ($urandom_range(0, 23) == 0);
            rpc = 9'($urandom) & 9'h1FC;
            if ((c / 200) % 2 == 0) rdy = ($urandom_range(0, 3) != 0);
            else                    rdy = ($urandom_range(0, 3) == 0);
            step(0, rd, rpc, rdy);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
